param_datapath: RTL and testbench
=================================

# param_datapath

Parametrised successor to the single-bus CPU datapath: one shared bus, NUM_REGS general registers and a DATA_W-bit data path. Adds one-hot bus-source arbitration with conflict flagging, and an iterative signed multiply/divide sequencer with a start/busy/done handshake. Sits between the control unit (per-cycle strobes) and memory/IO.

## Interface
Parameters:
- DATA_W, 32, datapath width; legal range is 24 and up.
- NUM_REGS, 16, general registers; legal range is 2 to 32.
- CONST_W, 19, width of the immediate field IR[CONST_W-1:0].

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- clr  in  1  reset, asynchronous and active-high.
- bus_out_sel  in  NUM_REGS+8  one-hot bus source select.
  - Indices 0..NUM_REGS-1 are the registers.
  - Indices NUM_REGS+0..7 are HI, LO, ZHI, ZLO, PC, MDR, INPORT, CSIGN.
- reg_in_en  in  NUM_REGS  per-register load enable.
- ba_out  in  1  R0 reads as 0 on the bus.
- y_in, z_in, hi_in, lo_in, pc_in, inc_pc, mar_in, mdr_in, ir_in, out_port_in  in  1  load strobes.
- read  in  1  MDR source select: 1 selects mdatain, 0 selects the bus.
- con_in  in  1  CON flip-flop load.
- mdatain  in  DATA_W  memory read data.
- in_port_data  in  DATA_W  input port; registered every cycle.
- alu_op  in  5  operation code.
- alu_start  in  1  launches multiply or divide.
- alu_busy  out  1  sequencer running.
- alu_done  out  1  one-cycle pulse marking multi-cycle result written to Z.
- con_out  out  1  branch condition.
- bus_conflict  out  1  more than one bus_out_sel bit is set (combinational).
- mar_addr, ir_data, out_port_data  out  DATA_W  register contents.

## Operation
- **Bus**
  - Lowest set index of bus_out_sel wins; bus_conflict=1 whenever two or more bits are set.
  - Bus is 0 when no bit is set.
  - R0 selected with ba_out=1 drives 0.
  - CSIGN is IR[CONST_W-1:0] sign-extended to DATA_W.
- **Registers:** load from the bus when their enable is high.
- **PC:** pc_in loads the bus; inc_pc adds 1 modulo 2^DATA_W; pc_in wins when both are high.
- **MDR:** loads on mdr_in, from mdatain when read=1, otherwise from the bus.
- **Single-cycle ALU:** result = Y op bus; on z_in, ZLO=result and ZHI=0. Ops:
  - ADD 0, SUB 1, AND 2, OR 3, SHR 4, SHRA 5, SHL 6, ROR 7, ROL 8, NEG 9, NOT 10.
  - Shift amount is bus[$clog2(DATA_W)-1:0].
  - Undefined codes give 0.
- **MUL 11 / DIV 12 (signed)**
  - alu_start latches Y and the bus as operands.
  - States: IDLE → RUN (DATA_W cycles, one shift-add or restoring-subtract step per cycle on magnitudes) → FIX (sign correction, write Z) → IDLE.
  - MUL writes ZHI:ZLO = full 2·DATA_W product.
  - DIV writes ZLO = quotient truncated toward 0 and ZHI = remainder, which carries the dividend's sign.
  - Divide by zero: ZLO = all-ones, ZHI = dividend.
- **CON:** on con_in, con_out is computed from IR[20:19] applied to the bus value:
  - 00: bus==0.
  - 01: bus!=0.
  - 10: bus≥0 (signed).
  - 11: bus<0.

## Timing
- Reset values: every register, Z, PC, MAR, MDR, IR, in/out port, con_out, alu_busy and alu_done are 0; the sequencer is in IDLE.
- Single-cycle ops: Z is valid the cycle after the z_in edge.
- Multi-cycle handshake:
  - alu_start is sampled at edge E0; alu_busy is high from E0 until edge E0+DATA_W+1.
  - Z is written at edge E0+DATA_W+1; alu_done is high for the following cycle only.
- Ignored inputs:
  - alu_start while busy is ignored.
  - alu_start with a non-MUL/DIV op is ignored.
  - z_in while busy is ignored; the sequencer owns Z.
- Back-to-back: alu_start may be asserted in the alu_done cycle and is accepted.
- clr mid-operation: the sequencer returns to IDLE immediately, and Z, busy and done all go to 0.

## Configuration
- PARAM_DATAPATH_MULDIV_EN defined: sequencer present, behaviour as above.
- PARAM_DATAPATH_MULDIV_EN undefined: no sequencer.
  - MUL/DIV behave as undefined single-cycle codes; Z is written 0 on z_in.
  - alu_start is ignored; alu_busy and alu_done are tied to 0.

## Structure
- Package datapath_pkg holds:
  - alu_op codes;
  - bus source index offsets (SRC_HI … SRC_CSIGN relative to NUM_REGS);
  - CON condition codes;
  - sequencer state enum.
- Sub-module muldiv_seq holds the operand latches, step counter, FSM and sign fix. It outputs 2·DATA_W and is instantiated under the macro.

## Test plan
- **Bus priority and conflict:** bus_out_sel selects R3 and PC with R3=0x11, PC=0x22 → bus=0x11 and bus_conflict=1. With no source selected → bus=0.
- **R0 with ba_out:** R0=0x5, ba_out=1, R1 loaded from R0 → R1=0.
- **MUL:** Y=−3, bus=7, alu_start → busy for 33 cycles, then done pulse; ZHI=0xFFFFFFFF, ZLO=0xFFFFFFEB.
- **DIV:**
  - Y=−7, bus=2 → ZLO=−3, ZHI=−1.
  - Divisor 0 with Y=9 → ZLO=0xFFFFFFFF, ZHI=9.
- **Reset mid-MUL:** clr asserted at cycle 10 of RUN → busy=0, Z=0, no done pulse. A new start afterwards completes correctly.
- **CON and PC:**
  - IR[20:19]=11 with bus=0x80000000 and con_in → con_out=1.
  - pc_in and inc_pc together with bus=0x40 → PC=0x40.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared definitions for param_datapath: ALU op codes, bus source offsets,
// CON condition codes and the multiply/divide sequencer state encoding.
package datapath_pkg;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_AND  = 5'd2,
    ALU_OR   = 5'd3,
    ALU_SHR  = 5'd4,
    ALU_SHRA = 5'd5,
    ALU_SHL  = 5'd6,
    ALU_ROR  = 5'd7,
    ALU_ROL  = 5'd8,
    ALU_NEG  = 5'd9,
    ALU_NOT  = 5'd10,
    ALU_MUL  = 5'd11,
    ALU_DIV  = 5'd12
  } alu_op_e;

  // Bus source indices above the general registers, relative to NUM_REGS.
  localparam int SRC_HI     = 0;
  localparam int SRC_LO     = 1;
  localparam int SRC_ZHI    = 2;
  localparam int SRC_ZLO    = 3;
  localparam int SRC_PC     = 4;
  localparam int SRC_MDR    = 5;
  localparam int SRC_INPORT = 6;
  localparam int SRC_CSIGN  = 7;
  localparam int NUM_FIXED_SRC = 8;

  typedef enum logic [1:0] {
    CON_ZERO    = 2'b00,
    CON_NONZERO = 2'b01,
    CON_GE      = 2'b10,
    CON_LT      = 2'b11
  } con_code_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/param_datapath_muldiv_seq.sv
// Iterative signed multiply/divide sequencer: latches operands, runs DATA_W
// shift-add / restoring-subtract steps on magnitudes, then applies signs.
module muldiv_seq
  import datapath_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  start,
  input  logic [4:0]            op,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  busy,
  output logic                  done,
  output logic                  wr,
  output logic [2*DATA_W-1:0]   result
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  seq_state_e          state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic                is_div;
  logic                accept;
  logic [DATA_W-1:0]   a_q, b_q, lo, lo_nxt, a_mag_in, b_mag, quo, rem;
  logic [DATA_W:0]     hi, hi_nxt, sum, shifted, trial;
  logic [2*DATA_W-1:0] prod;

  assign accept = start && (state == S_IDLE) && ((op == ALU_MUL) || (op == ALU_DIV));
  assign wr     = (state == S_FIX);

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = accept ? S_RUN : S_IDLE;
      S_RUN:   state_nxt = (cnt == CNT_W'(DATA_W - 1)) ? S_FIX : S_RUN;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // One iteration: hi:lo is the partial product, or remainder:quotient.
  always_comb begin
    a_mag_in = a[DATA_W-1] ? -a : a;
    b_mag    = b_q[DATA_W-1] ? -b_q : b_q;
    sum      = {1'b0, hi[DATA_W-1:0]} + (lo[0] ? {1'b0, b_mag} : '0);
    shifted  = {hi[DATA_W-1:0], lo[DATA_W-1]};
    trial    = shifted - {1'b0, b_mag};
    hi_nxt   = hi;
    lo_nxt   = lo;
    if (is_div) begin
      if (trial[DATA_W]) begin
        hi_nxt = shifted;
        lo_nxt = {lo[DATA_W-2:0], 1'b0};
      end else begin
        hi_nxt = trial;
        lo_nxt = {lo[DATA_W-2:0], 1'b1};
      end
    end else begin
      hi_nxt = {1'b0, sum[DATA_W:1]};
      lo_nxt = {sum[0], lo[DATA_W-1:1]};
    end
  end

  // Sign correction; a zero divisor returns all-ones and the raw dividend.
  always_comb begin
    prod = {hi[DATA_W-1:0], lo};
    quo  = (a_q[DATA_W-1] ^ b_q[DATA_W-1]) ? -lo : lo;
    rem  = a_q[DATA_W-1] ? -hi[DATA_W-1:0] : hi[DATA_W-1:0];
    if (!is_div) begin
      result = (a_q[DATA_W-1] ^ b_q[DATA_W-1]) ? -prod : prod;
    end else if (b_q == '0) begin
      result = {a_q, {DATA_W{1'b1}}};
    end else begin
      result = {rem, quo};
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= S_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == S_FIX);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt    <= '0;
      is_div <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_q    <= a;
            b_q    <= b;
            is_div <= (op == ALU_DIV);
            hi     <= '0;
            lo     <= a_mag_in;
            cnt    <= '0;
            busy   <= 1'b1;
          end
        end
        S_RUN: begin
          hi  <= hi_nxt;
          lo  <= lo_nxt;
          cnt <= cnt + CNT_W'(1);
        end
        S_FIX:   busy <= 1'b0;
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/param_datapath.sv
// Single shared-bus datapath with NUM_REGS registers and a one-hot bus source.
// Macro PARAM_DATAPATH_MULDIV_EN adds the iterative signed MUL/DIV sequencer.
module param_datapath
  import datapath_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int CONST_W  = 19
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [NUM_REGS+7:0]      bus_out_sel,
  input  logic [NUM_REGS-1:0]      reg_in_en,
  input  logic                     ba_out,
  input  logic                     y_in,
  input  logic                     z_in,
  input  logic                     hi_in,
  input  logic                     lo_in,
  input  logic                     pc_in,
  input  logic                     inc_pc,
  input  logic                     mar_in,
  input  logic                     mdr_in,
  input  logic                     ir_in,
  input  logic                     out_port_in,
  input  logic                     read,
  input  logic                     con_in,
  input  logic [DATA_W-1:0]        mdatain,
  input  logic [DATA_W-1:0]        in_port_data,
  input  logic [4:0]               alu_op,
  input  logic                     alu_start,
  output logic                     alu_busy,
  output logic                     alu_done,
  output logic                     con_out,
  output logic                     bus_conflict,
  output logic [DATA_W-1:0]        mar_addr,
  output logic [DATA_W-1:0]        ir_data,
  output logic [DATA_W-1:0]        out_port_data
);

  localparam int SEL_W = NUM_REGS + NUM_FIXED_SRC;
  localparam int SH_W  = $clog2(DATA_W);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [DATA_W-1:0]   src  [SEL_W];
  logic [DATA_W-1:0]   y, hi, lo, zhi, zlo, pc, mar, mdr, ir, in_port, out_port;
  logic [DATA_W-1:0]   bus, alu_res;
  logic [2*DATA_W-1:0] rot_r, rot_l;
  logic [SH_W-1:0]     shamt;
  logic                seq_wr;
  logic [2*DATA_W-1:0] seq_res;

  assign mar_addr      = mar;
  assign ir_data       = ir;
  assign out_port_data = out_port;
  assign bus_conflict  = |(bus_out_sel & (bus_out_sel - SEL_W'(1)));
  assign shamt         = bus[SH_W-1:0];

  // Bus sources and lowest-index-wins selection.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) src[i] = regs[i];
    if (ba_out) src[0] = '0;
    else        src[0] = regs[0];
    src[NUM_REGS+SRC_HI]     = hi;
    src[NUM_REGS+SRC_LO]     = lo;
    src[NUM_REGS+SRC_ZHI]    = zhi;
    src[NUM_REGS+SRC_ZLO]    = zlo;
    src[NUM_REGS+SRC_PC]     = pc;
    src[NUM_REGS+SRC_MDR]    = mdr;
    src[NUM_REGS+SRC_INPORT] = in_port;
    src[NUM_REGS+SRC_CSIGN]  = {{(DATA_W-CONST_W){ir[CONST_W-1]}}, ir[CONST_W-1:0]};
    bus = '0;
    for (int i = SEL_W - 1; i >= 0; i--) bus = bus_out_sel[i] ? src[i] : bus;
  end

  // Single-cycle ALU: Y op bus.
  always_comb begin
    alu_res = '0;
    rot_r   = {y, y} >> shamt;
    rot_l   = {y, y} << shamt;
    case (alu_op)
      ALU_ADD:  alu_res = y + bus;
      ALU_SUB:  alu_res = y - bus;
      ALU_AND:  alu_res = y & bus;
      ALU_OR:   alu_res = y | bus;
      ALU_SHR:  alu_res = y >> shamt;
      ALU_SHRA: alu_res = $signed(y) >>> shamt;
      ALU_SHL:  alu_res = y << shamt;
      ALU_ROR:  alu_res = rot_r[DATA_W-1:0];
      ALU_ROL:  alu_res = rot_l[2*DATA_W-1:DATA_W];
      ALU_NEG:  alu_res = -bus;
      ALU_NOT:  alu_res = ~bus;
      default:  alu_res = '0;
    endcase
  end

`ifdef PARAM_DATAPATH_MULDIV_EN
  muldiv_seq #(.DATA_W(DATA_W)) u_seq (
    .clk    (clk),
    .clr    (clr),
    .start  (alu_start),
    .op     (alu_op),
    .a      (y),
    .b      (bus),
    .busy   (alu_busy),
    .done   (alu_done),
    .wr     (seq_wr),
    .result (seq_res)
  );
`else
  logic unused_start;
  assign unused_start = alu_start;
  assign seq_wr       = 1'b0;
  assign seq_res      = '0;
  assign alu_busy     = 1'b0;
  assign alu_done     = 1'b0;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (reg_in_en[i]) regs[i] <= bus;
      end
    end
  end

  // Special registers; the sequencer owns Z while it is busy.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      y <= '0; hi <= '0; lo <= '0; zhi <= '0; zlo <= '0; pc <= '0;
      mar <= '0; mdr <= '0; ir <= '0; in_port <= '0; out_port <= '0;
      con_out <= 1'b0;
    end else begin
      in_port <= in_port_data;
      if (y_in)        y        <= bus;
      if (hi_in)       hi       <= bus;
      if (lo_in)       lo       <= bus;
      if (mar_in)      mar      <= bus;
      if (ir_in)       ir       <= bus;
      if (out_port_in) out_port <= bus;
      if (mdr_in)      mdr      <= read ? mdatain : bus;
      if (pc_in)       pc       <= bus;
      else if (inc_pc) pc       <= pc + DATA_W'(1);
      if (seq_wr) begin
        {zhi, zlo} <= seq_res;
      end else if (z_in && !alu_busy) begin
        zlo <= alu_res;
        zhi <= '0;
      end
      if (con_in) begin
        case (ir[20:19])
          CON_ZERO:    con_out <= (bus == '0);
          CON_NONZERO: con_out <= (bus != '0);
          CON_GE:      con_out <= ~bus[DATA_W-1];
          CON_LT:      con_out <= bus[DATA_W-1];
          default:     con_out <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_param_datapath.sv
// Self-checking bench for param_datapath (default parameters) with randomized
// stimulus against an arithmetic reference model.
module tb_param_datapath;

  localparam int S_HI = 16, S_LO = 17, S_ZHI = 18, S_ZLO = 19;
  localparam int S_PC = 20, S_MDR = 21, S_IN = 22, S_CS = 23;
  localparam int D_Y = 0, D_IR = 1, D_PC = 2, D_HI = 3, D_LO = 4, D_MAR = 5;

  logic        clk, clr;
  logic [23:0] bus_out_sel;
  logic [15:0] reg_in_en;
  logic        ba_out, y_in, z_in, hi_in, lo_in, pc_in, inc_pc, mar_in, mdr_in;
  logic        ir_in, out_port_in, read, con_in, alu_start;
  logic [31:0] mdatain, in_port_data;
  logic [4:0]  alu_op;
  logic        alu_busy, alu_done, con_out, bus_conflict;
  logic [31:0] mar_addr, ir_data, out_port_data;

  int n_checks = 0;
  int n_fail   = 0;

  param_datapath dut (
    .clk(clk), .clr(clr), .bus_out_sel(bus_out_sel), .reg_in_en(reg_in_en),
    .ba_out(ba_out), .y_in(y_in), .z_in(z_in), .hi_in(hi_in), .lo_in(lo_in),
    .pc_in(pc_in), .inc_pc(inc_pc), .mar_in(mar_in), .mdr_in(mdr_in), .ir_in(ir_in),
    .out_port_in(out_port_in), .read(read), .con_in(con_in), .mdatain(mdatain),
    .in_port_data(in_port_data), .alu_op(alu_op), .alu_start(alu_start),
    .alu_busy(alu_busy), .alu_done(alu_done), .con_out(con_out),
    .bus_conflict(bus_conflict), .mar_addr(mar_addr), .ir_data(ir_data),
    .out_port_data(out_port_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] alu_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int s;
    logic [31:0] r;
    s = int'(b[4:0]);
    r = a;
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a & b;
      5'd3:  return a | b;
      5'd4:  return a >> s;
      5'd5:  begin for (int k = 0; k < s; k++) r = {r[31], r[31:1]}; return r; end
      5'd6:  return a << s;
      5'd7:  begin for (int k = 0; k < s; k++) r = {r[0], r[31:1]}; return r; end
      5'd8:  begin for (int k = 0; k < s; k++) r = {r[30:0], r[31]}; return r; end
      5'd9:  return 32'd0 - b;
      5'd10: return ~b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [63:0] md_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    sa = $signed(a);
    sb = $signed(b);
    if (op == 5'd11) return sa * sb;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic con_model(input logic [1:0] c, input logic [31:0] v);
    case (c)
      2'b00:   return v == 32'd0;
      2'b01:   return v != 32'd0;
      2'b10:   return $signed(v) >= 0;
      default: return $signed(v) < 0;
    endcase
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus_out_sel = '0; reg_in_en = '0; ba_out = 1'b0; y_in = 1'b0; z_in = 1'b0;
    hi_in = 1'b0; lo_in = 1'b0; pc_in = 1'b0; inc_pc = 1'b0; mar_in = 1'b0;
    mdr_in = 1'b0; ir_in = 1'b0; out_port_in = 1'b0; read = 1'b0; con_in = 1'b0;
    alu_start = 1'b0; alu_op = 5'd0;
  endtask

  task automatic put_in(input logic [31:0] v);
    in_port_data = v;
    tick();
  endtask

  task automatic load_reg(input int idx, input logic [31:0] v);
    put_in(v);
    idle(); bus_out_sel[S_IN] = 1'b1; reg_in_en[idx] = 1'b1;
    tick(); idle();
  endtask

  task automatic load_sp(input int d, input logic [31:0] v);
    put_in(v);
    idle(); bus_out_sel[S_IN] = 1'b1;
    case (d)
      D_Y:  y_in = 1'b1;
      D_IR: ir_in = 1'b1;
      D_PC: pc_in = 1'b1;
      D_HI: hi_in = 1'b1;
      D_LO: lo_in = 1'b1;
      default: mar_in = 1'b1;
    endcase
    tick(); idle();
  endtask

  task automatic read_src(input int s, output logic [31:0] v);
    idle(); bus_out_sel[s] = 1'b1; out_port_in = 1'b1;
    tick(); idle();
    v = out_port_data;
  endtask

  task automatic start_md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    load_sp(D_Y, a);
    put_in(b);
    idle(); bus_out_sel[S_IN] = 1'b1; alu_op = op; alu_start = 1'b1;
    tick(); idle();
  endtask

  task automatic wait_busy(output int cycles);
    cycles = 0;
    while (alu_busy && cycles < 200) begin
      cycles++;
      tick();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] v;
    idle(); in_port_data = 32'd0; mdatain = 32'd0; clr = 1'b1;
    tick(); tick(); #1;
    n_checks++; if (mar_addr !== 32'd0) begin n_fail++; $display("FAIL reset_mar: got %h expected 0", mar_addr); end
    n_checks++; if (ir_data !== 32'd0) begin n_fail++; $display("FAIL reset_ir: got %h expected 0", ir_data); end
    n_checks++; if (out_port_data !== 32'd0) begin n_fail++; $display("FAIL reset_out: got %h expected 0", out_port_data); end
    n_checks++; if (con_out !== 1'b0) begin n_fail++; $display("FAIL reset_con: got %b expected 0", con_out); end
    n_checks++; if (alu_busy !== 1'b0 || alu_done !== 1'b0) begin n_fail++; $display("FAIL reset_seq: busy %b done %b expected 0 0", alu_busy, alu_done); end
    @(negedge clk); clr = 1'b0;
    read_src(5, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL reset_r5: got %h expected 0", v); end
    read_src(S_PC, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", v); end
    read_src(S_ZLO, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL reset_zlo: got %h expected 0", v); end
  endtask

  task automatic test_bus();
    logic [31:0] mregs [16];
    logic [31:0] v, exp, irv;
    logic [15:0] sel;
    load_reg(3, 32'h11);
    load_sp(D_PC, 32'h22);
    idle(); bus_out_sel[3] = 1'b1; bus_out_sel[S_PC] = 1'b1; out_port_in = 1'b1; #1;
    n_checks++; if (bus_conflict !== 1'b1) begin n_fail++; $display("FAIL bus_conflict_r3pc: got %b expected 1", bus_conflict); end
    tick(); idle();
    n_checks++; if (out_port_data !== 32'h11) begin n_fail++; $display("FAIL bus_prio_r3pc: got %h expected 11", out_port_data); end
    out_port_in = 1'b1; #1;
    n_checks++; if (bus_conflict !== 1'b0) begin n_fail++; $display("FAIL bus_conflict_none: got %b expected 0", bus_conflict); end
    tick(); idle();
    n_checks++; if (out_port_data !== 32'd0) begin n_fail++; $display("FAIL bus_none: got %h expected 0", out_port_data); end
    for (int i = 0; i < 16; i++) begin mregs[i] = $urandom; load_reg(i, mregs[i]); end
    for (int t = 0; t < 20; t++) begin
      sel = (t < 8) ? (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15)) : 16'($urandom);
      exp = 32'd0;
      for (int i = 15; i >= 0; i--) if (sel[i]) exp = mregs[i];
      idle(); bus_out_sel[15:0] = sel; out_port_in = 1'b1; #1;
      n_checks++; if (bus_conflict !== ($countones(sel) > 1)) begin n_fail++; $display("FAIL bus_rand_conflict: sel %h got %b", sel, bus_conflict); end
      tick(); idle();
      n_checks++; if (out_port_data !== exp) begin n_fail++; $display("FAIL bus_rand: sel %h got %h expected %h", sel, out_port_data, exp); end
    end
    irv = $urandom;
    load_sp(D_IR, irv);
    n_checks++; if (ir_data !== irv) begin n_fail++; $display("FAIL ir_load: got %h expected %h", ir_data, irv); end
    read_src(S_CS, v);
    exp = irv[18] ? (irv | 32'hFFF8_0000) : (irv & 32'h0007_FFFF);
    n_checks++; if (v !== exp) begin n_fail++; $display("FAIL csign: got %h expected %h", v, exp); end
    v = $urandom;
    load_sp(D_MAR, v);
    n_checks++; if (mar_addr !== v) begin n_fail++; $display("FAIL mar_load: got %h expected %h", mar_addr, v); end
    exp = $urandom;
    load_sp(D_HI, exp);
    read_src(S_HI, v);
    n_checks++; if (v !== exp) begin n_fail++; $display("FAIL hi_load: got %h expected %h", v, exp); end
    exp = $urandom;
    load_sp(D_LO, exp);
    read_src(S_LO, v);
    n_checks++; if (v !== exp) begin n_fail++; $display("FAIL lo_load: got %h expected %h", v, exp); end
    mdatain = $urandom;
    idle(); bus_out_sel[7] = 1'b1; read = 1'b1; mdr_in = 1'b1; tick(); idle();
    read_src(S_MDR, v);
    n_checks++; if (v !== mdatain) begin n_fail++; $display("FAIL mdr_mem: got %h expected %h", v, mdatain); end
    idle(); bus_out_sel[5] = 1'b1; mdr_in = 1'b1; tick(); idle();
    read_src(S_MDR, v);
    n_checks++; if (v !== mregs[5]) begin n_fail++; $display("FAIL mdr_bus: got %h expected %h", v, mregs[5]); end
  endtask

  task automatic test_ba_out();
    logic [31:0] v;
    load_reg(0, 32'h5);
    load_reg(1, 32'hABCD);
    idle(); ba_out = 1'b1; bus_out_sel[0] = 1'b1; reg_in_en[1] = 1'b1; tick(); idle();
    read_src(1, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL ba_out_r0: got %h expected 0", v); end
    idle(); bus_out_sel[0] = 1'b1; reg_in_en[1] = 1'b1; tick(); idle();
    read_src(1, v);
    n_checks++; if (v !== 32'h5) begin n_fail++; $display("FAIL r0_plain: got %h expected 5", v); end
  endtask

  task automatic test_pc();
    logic [31:0] v;
    put_in(32'h40);
    idle(); bus_out_sel[S_IN] = 1'b1; pc_in = 1'b1; inc_pc = 1'b1; tick(); idle();
    read_src(S_PC, v);
    n_checks++; if (v !== 32'h40) begin n_fail++; $display("FAIL pc_load_wins: got %h expected 40", v); end
    inc_pc = 1'b1; tick(); idle();
    read_src(S_PC, v);
    n_checks++; if (v !== 32'h41) begin n_fail++; $display("FAIL pc_inc: got %h expected 41", v); end
    load_sp(D_PC, 32'hFFFF_FFFF);
    inc_pc = 1'b1; tick(); idle();
    read_src(S_PC, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL pc_wrap: got %h expected 0", v); end
  endtask

  task automatic test_alu();
    logic [31:0] a, b, v, exp;
    logic [4:0]  op;
    for (int t = 0; t < 40; t++) begin
      op = (t < 13) ? 5'(t) : 5'($urandom_range(0, 15));
      a = $urandom;
      b = (t % 3 == 0) ? 32'($urandom_range(0, 31)) : $urandom;
      exp = alu_model(op, a, b);
      load_sp(D_Y, a);
      put_in(b);
      idle(); bus_out_sel[S_IN] = 1'b1; alu_op = op; z_in = 1'b1; tick(); idle();
      read_src(S_ZLO, v);
      n_checks++; if (v !== exp) begin n_fail++; $display("FAIL alu_zlo: op %0d y %h b %h got %h expected %h", op, a, b, v, exp); end
      read_src(S_ZHI, v);
      n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL alu_zhi: op %0d got %h expected 0", op, v); end
    end
  endtask

  task automatic test_con();
    logic [31:0] irv, v;
    logic [1:0]  c;
    logic        exp;
    for (int t = 0; t < 16; t++) begin
      c = (t == 0) ? 2'b11 : 2'(t % 4);
      case (t % 5)
        0: v = 32'h8000_0000;
        1: v = 32'd0;
        2: v = 32'h7FFF_FFFF;
        default: v = $urandom;
      endcase
      irv = ($urandom & 32'hFFE7_FFFF) | (32'(c) << 19);
      exp = con_model(c, v);
      load_sp(D_IR, irv);
      put_in(v);
      idle(); bus_out_sel[S_IN] = 1'b1; con_in = 1'b1; tick(); idle();
      n_checks++; if (con_out !== exp) begin n_fail++; $display("FAIL con: code %b bus %h got %b expected %b", c, v, con_out, exp); end
    end
  endtask

`ifdef PARAM_DATAPATH_MULDIV_EN
  task automatic test_muldiv();
    logic [31:0] a, b, zl, zh;
    logic [4:0]  op;
    logic [63:0] exp;
    int          cyc;
    for (int t = 0; t < 11; t++) begin
      case (t)
        0: begin op = 5'd11; a = 32'hFFFF_FFFD; b = 32'd7; end
        1: begin op = 5'd12; a = 32'hFFFF_FFF9; b = 32'd2; end
        2: begin op = 5'd12; a = 32'd9; b = 32'd0; end
        3: begin op = 5'd12; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        4: begin op = 5'd11; a = 32'h8000_0000; b = 32'h8000_0000; end
        default: begin op = 5'($urandom_range(11, 12)); a = $urandom; b = (t == 5) ? 32'($urandom_range(1, 9)) : $urandom; end
      endcase
      exp = md_model(op, a, b);
      start_md(op, a, b);
      if (t == 1) begin
        // Restart and a Z write are both attempted while the sequencer runs.
        bus_out_sel[S_IN] = 1'b1; alu_op = 5'd11; alu_start = 1'b1; z_in = 1'b1;
      end
      wait_busy(cyc);
      idle();
      n_checks++; if (cyc !== 33) begin n_fail++; $display("FAIL md_busy_len: got %0d cycles expected 33", cyc); end
      n_checks++; if (alu_done !== 1'b1) begin n_fail++; $display("FAIL md_done_pulse: got %b expected 1", alu_done); end
      tick();
      n_checks++; if (alu_done !== 1'b0) begin n_fail++; $display("FAIL md_done_width: got %b expected 0", alu_done); end
      read_src(S_ZLO, zl);
      read_src(S_ZHI, zh);
      n_checks++; if ({zh, zl} !== exp) begin n_fail++; $display("FAIL md_result: op %0d a %h b %h got %h expected %h", op, a, b, {zh, zl}, exp); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a2, b2, zl, zh;
    logic [63:0] exp1, exp2;
    int          g;
    a2 = 32'hFFFF_FF9C; b2 = 32'd7;
    exp1 = md_model(5'd11, 32'h1234, 32'hFFFF_0001);
    exp2 = md_model(5'd12, a2, b2);
    start_md(5'd11, 32'h1234, 32'hFFFF_0001);
    load_sp(D_Y, a2);
    put_in(b2);
    g = 0;
    while (!alu_done && g < 100) begin g++; tick(); end
    n_checks++; if (alu_done !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done: got %b expected 1", alu_done); end
    idle(); bus_out_sel[S_IN] = 1'b1; alu_op = 5'd12; alu_start = 1'b1; tick(); idle();
    n_checks++; if (alu_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: busy %b expected 1", alu_busy); end
    read_src(S_ZLO, zl);
    read_src(S_ZHI, zh);
    n_checks++; if ({zh, zl} !== exp1) begin n_fail++; $display("FAIL b2b_first: got %h expected %h", {zh, zl}, exp1); end
    wait_busy(g);
    idle(); tick();
    read_src(S_ZLO, zl);
    read_src(S_ZHI, zh);
    n_checks++; if ({zh, zl} !== exp2) begin n_fail++; $display("FAIL b2b_second: got %h expected %h", {zh, zl}, exp2); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] zl, zh, a, b;
    logic [63:0] exp;
    int          dones, cyc;
    start_md(5'd11, $urandom | 32'h1, $urandom | 32'h1);
    repeat (10) tick();
    clr = 1'b1; #2;
    n_checks++; if (alu_busy !== 1'b0 || alu_done !== 1'b0) begin n_fail++; $display("FAIL clr_mid_seq: busy %b done %b expected 0 0", alu_busy, alu_done); end
    @(negedge clk); clr = 1'b0;
    read_src(S_ZLO, zl);
    read_src(S_ZHI, zh);
    n_checks++; if ({zh, zl} !== 64'd0) begin n_fail++; $display("FAIL clr_mid_z: got %h expected 0", {zh, zl}); end
    dones = 0;
    for (int i = 0; i < 40; i++) begin if (alu_done || alu_busy) dones++; tick(); end
    n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL clr_mid_quiet: got %0d active cycles expected 0", dones); end
    a = $urandom; b = $urandom;
    exp = md_model(5'd11, a, b);
    start_md(5'd11, a, b);
    wait_busy(cyc);
    idle(); tick();
    read_src(S_ZLO, zl);
    read_src(S_ZHI, zh);
    n_checks++; if ({zh, zl} !== exp) begin n_fail++; $display("FAIL clr_mid_restart: got %h expected %h", {zh, zl}, exp); end
  endtask
`else
  task automatic test_muldiv_disabled();
    logic [31:0] zl, zh;
    int          act;
    load_sp(D_Y, 32'd5);
    put_in(32'd6);
    idle(); bus_out_sel[S_IN] = 1'b1; z_in = 1'b1; tick(); idle();
    start_md(5'd11, 32'd3, 32'd4);
    act = 0;
    for (int i = 0; i < 40; i++) begin if (alu_busy || alu_done) act++; tick(); end
    n_checks++; if (act !== 0) begin n_fail++; $display("FAIL nomd_quiet: got %0d active cycles expected 0", act); end
    read_src(S_ZLO, zl);
    n_checks++; if (zl !== 32'd11) begin n_fail++; $display("FAIL nomd_z_kept: got %h expected b", zl); end
    for (int k = 11; k <= 12; k++) begin
      put_in(32'd4);
      idle(); bus_out_sel[S_IN] = 1'b1; alu_op = 5'(k); z_in = 1'b1; tick(); idle();
      read_src(S_ZLO, zl);
      read_src(S_ZHI, zh);
      n_checks++; if ({zh, zl} !== 64'd0) begin n_fail++; $display("FAIL nomd_op%0d: got %h expected 0", k, {zh, zl}); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_bus();
    test_ba_out();
    test_pc();
    test_alu();
    test_con();
`ifdef PARAM_DATAPATH_MULDIV_EN
    test_muldiv();
    test_back_to_back();
    test_reset_mid();
`else
    test_muldiv_disabled();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
